// File: rtl/diff_rx_pkg.sv
// Shared types and legal parameter ranges for the differential receive filter.
package diff_rx_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } filt_state_e;

  localparam int unsigned NCH_MIN    = 1;
  localparam int unsigned NCH_MAX    = 16;
  localparam int unsigned SYNC_MIN   = 2;
  localparam int unsigned SYNC_MAX   = 4;
  localparam int unsigned FILT_MIN   = 1;
  localparam int unsigned FILT_MAX   = 15;
  localparam int unsigned ERR_W_MIN  = 2;
  localparam int unsigned ERR_W_MAX  = 16;

  // Filter count width covers FILT_MAX.
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/diff_rx_chan.sv
// One differential channel: pin synchronisers, pair decode, glitch filter FSM
// and saturating error counter.
module diff_rx_chan
  import diff_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             ib,
  input  logic             en,
  input  logic             clr_err,
  output logic             o,
  output logic             invalid,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] i_sync;
  logic [SYNC_STAGES-1:0] ib_sync;
  logic                   dec_invalid_c;
  logic                   dec_level_c;
  logic                   differs_c;

  filt_state_e            state;
  filt_state_e            state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   o_nxt;

  // Reset presets the chain to a valid-0 pair so release never looks like an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_sync  <= '0;
      ib_sync <= '1;
    end else begin
      i_sync  <= {i_sync[SYNC_STAGES-2:0], i};
      ib_sync <= {ib_sync[SYNC_STAGES-2:0], ib};
    end
  end

  assign dec_invalid_c = ~(i_sync[SYNC_STAGES-1] ^ ib_sync[SYNC_STAGES-1]);
  assign dec_level_c   = i_sync[SYNC_STAGES-1];
  assign differs_c     = ~dec_invalid_c & (dec_level_c != o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      o     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      o     <= o_nxt;
    end
  end

  // The edge that would bring the count to FILT_LEN toggles O instead.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    o_nxt     = o;
    if (!en) begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        STABLE: begin
          cnt_nxt = '0;
          if (differs_c) begin
            if (FILT_LEN == 1) begin
              o_nxt = ~o;
            end else begin
              state_nxt = PEND;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        PEND: begin
          if (!differs_c) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt == LAST_CNT) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
            o_nxt     = ~o;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // invalid doubles as the previous-cycle decode for valid->invalid edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      invalid <= 1'b0;
      err_cnt <= '0;
    end else begin
      invalid <= dec_invalid_c;
      if (clr_err) begin
        err_cnt <= '0;
      end else if (dec_invalid_c && !invalid && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: rtl/diff_rx_filter.sv
// Multi-channel differential receiver filter: NCH independent channels plus
// a registered any-error flag.
module diff_rx_filter
  import diff_rx_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned ERR_W       = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NCH-1:0]     I,
  input  logic [NCH-1:0]     IB,
  input  logic               EN,
  input  logic               CLR_ERR,
  output logic [NCH-1:0]     O,
  output logic [NCH-1:0]     INVALID,
  output logic [NCH*ERR_W-1:0] ERR_CNT,
  output logic               ERR_ANY
);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("diff_rx_filter: NCH out of range");
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("diff_rx_filter: SYNC_STAGES out of range");
  end
  if (FILT_LEN < FILT_MIN || FILT_LEN > FILT_MAX) begin : g_bad_filt
    $error("diff_rx_filter: FILT_LEN out of range");
  end
  if (ERR_W < ERR_W_MIN || ERR_W > ERR_W_MAX) begin : g_bad_err_w
    $error("diff_rx_filter: ERR_W out of range");
  end

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    diff_rx_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .ERR_W       (ERR_W)
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .i       (I[n]),
      .ib      (IB[n]),
      .en      (EN),
      .clr_err (CLR_ERR),
      .o       (O[n]),
      .invalid (INVALID[n]),
      .err_cnt (ERR_CNT[n*ERR_W +: ERR_W])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_ANY <= 1'b0;
    end else begin
      ERR_ANY <= |ERR_CNT;
    end
  end

endmodule

// File: doc/diff_rx_filter.md
DIFF_RX_FILTER -- requirements
Module: diff_rx_filter

Interface
REQ-001 Parameter NCH, default 4: number of differential channels, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per pin, legal range 2..4.
REQ-003 Parameter FILT_LEN, default 3: consecutive stable cycles required before O changes, legal range 1..15.
REQ-004 Parameter ERR_W, default 8: width of each per-channel error counter, legal range 2..16.
REQ-005 Port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port RST, input, 1: synchronous, active-high reset.
REQ-007 Port I, input, NCH: true leg of each differential pair, asynchronous to CLK.
REQ-008 Port IB, input, NCH: complement leg of each pair, asynchronous to CLK.
REQ-009 Port EN, input, 1: global filter enable.
REQ-010 Port CLR_ERR, input, 1: clears all error counters.
REQ-011 Port O, output, NCH: filtered decoded level per channel, registered.
REQ-012 Port INVALID, output, NCH: registered flag, high while the synchronised pair is 00 or 11.
REQ-013 Port ERR_CNT, output, NCH*ERR_W: packed error counters; channel n occupies bits [n*ERR_W +: ERR_W].
REQ-014 Port ERR_ANY, output, 1: registered OR of all ERR_CNT bits being nonzero.

Function
REQ-015 Each I and IB bit SHALL pass through its own SYNC_STAGES-deep flop chain before any decode.
REQ-016 The synchronised pair SHALL decode as (1,0) -> valid 1, (0,1) -> valid 0, and (0,0)/(1,1) -> invalid.
REQ-017 INVALID[n] SHALL equal the invalid decode, registered one cycle after the last sync stage.
REQ-018 Each channel SHALL run a 2-state FSM. STABLE: filter count = 0. PEND: a valid decode differs from O and the count is advancing.
REQ-019 STABLE->PEND SHALL occur when EN=1 and the valid decode differs from O; the count is set to 1.
REQ-020 In PEND, while EN=1, each cycle with a differing valid decode SHALL increment the count; when it reaches FILT_LEN, O SHALL toggle on that edge and the FSM SHALL return to STABLE.
REQ-021 In PEND, a valid decode equal to O, or an invalid decode, SHALL return the FSM to STABLE with count 0, and O SHALL hold.
REQ-022 With FILT_LEN=1, O SHALL change on the first edge at which it sees a differing valid decode.
REQ-023 Pin-to-O latency for a clean transition SHALL be exactly SYNC_STAGES+FILT_LEN cycles.
REQ-024 An invalid decode SHALL never change O; O holds its last valid value.
REQ-025 ERR_CNT[n] SHALL increment by 1 on each valid->invalid transition of the decode and SHALL saturate at all-ones.
REQ-026 When CLR_ERR=1, all counters SHALL become 0 on the next edge; clear wins over a simultaneous increment.
REQ-027 EN=0 SHALL force every FSM to STABLE and hold O. Synchronisers, INVALID and ERR_CNT SHALL keep operating.
REQ-028 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-029 RST=1 SHALL set O=0, INVALID=0, ERR_CNT=0, ERR_ANY=0, all FSMs to STABLE and all counts to 0.
REQ-030 RST SHALL preset the synchronisers to I=0, IB=1 (valid-0) so that reset release with no pin activity causes no spurious error count.
REQ-031 RST asserted mid-PEND SHALL abort the pending transition; O SHALL stay 0.

Structure
REQ-032 Package diff_rx_pkg SHALL hold the FSM state enum (STABLE, PEND) and the parameter range constants.
REQ-033 Sub-module diff_rx_chan SHALL implement one channel (synchroniser, decode, FSM, error counter); the top SHALL instantiate it NCH times and form ERR_ANY.
REQ-034 Parameter violations SHALL be caught by elaboration-time checks.

Verification (NCH=4, SYNC_STAGES=2, FILT_LEN=3, ERR_W=4)
REQ-035 Reset, then drive ch0 to I=1, IB=0 -> O[0] rises exactly 5 cycles later; other O bits stay 0.
REQ-036 Ch1 at valid-1 for 2 cycles, then back to valid-0 -> O[1] stays 0 and ERR_CNT ch1 stays 0.
REQ-037 Ch2 valid-1 -> 11 -> valid-1, with 11 held 4 cycles -> O[2] does not change during the 11 phase, INVALID[2] is high for 4 cycles, ERR_CNT ch2 = 1 and ERR_ANY = 1.
REQ-038 Drive 20 separate 00 pulses on ch3 -> ERR_CNT ch3 saturates at 15. CLR_ERR asserted together with a new pulse -> counter reads 0.
REQ-039 With EN=0, drive ch0 valid-1 for 10 cycles -> O[0] holds 0. Raise EN -> O[0] rises 3 cycles later.
REQ-040 Assert RST 2 cycles into a PEND on ch1 -> after release O[1]=0 and ERR_CNT=0, and the pending change must be re-qualified with a full FILT_LEN run.
